// File: rtl/rom_dispatch_pkg.sv
// rom_dispatch_pkg
// Shared types and sizing helpers for the ROM burst dispatcher.
//   state_t       : sequencer state {IDLE, RUN, DRAIN}
//   nports_f      : number of ROM output ports for a given log2 port count
//   grant_cnt_w_f : width of a per-beat word count (0..NPORTS)
//   rem_w_f       : width of the remaining-words counter (0..2**LOG_ROM_SIZE)
package rom_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_LOG_ROM_SIZE  = 8;
    localparam int DEF_LOG_OUT_PORTS = 2;

    function automatic int nports_f(input int log_out_ports);
        return 1 << log_out_ports;
    endfunction

    function automatic int grant_cnt_w_f(input int log_out_ports);
        return log_out_ports + 1;
    endfunction

    function automatic int rem_w_f(input int log_rom_size);
        return log_rom_size + 1;
    endfunction

endpackage

// File: rtl/rom_dispatch_ctrl_grant_sel.sv
// dispatch_grant_sel
// Combinational beat grant. Picks the lowest-index ready ports, stopping once
// the number of picked ports reaches the words still to be dispatched.
//   port_ready : per-port downstream ready
//   remaining  : words left in the burst
//   grant      : ports served this beat (ascending index gets ascending address)
//   k          : popcount(grant) = min(remaining, popcount(port_ready))
module dispatch_grant_sel
    import rom_dispatch_pkg::*;
#(
    parameter int LOG_ROM_SIZE  = DEF_LOG_ROM_SIZE,
    parameter int LOG_OUT_PORTS = DEF_LOG_OUT_PORTS,
    localparam int NPORTS = nports_f(LOG_OUT_PORTS),
    localparam int KW     = grant_cnt_w_f(LOG_OUT_PORTS),
    localparam int RW     = rem_w_f(LOG_ROM_SIZE)
)(
    input  logic [NPORTS-1:0] port_ready,
    input  logic [RW-1:0]     remaining,
    output logic [NPORTS-1:0] grant,
    output logic [KW-1:0]     k
);

    logic [KW-1:0] w_cnt;

    // Running count doubles as the cap test: a ready port is taken only while
    // fewer ports than remaining words have been granted so far.
    always_comb begin
        grant = '0;
        w_cnt = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (port_ready[i] && (RW'(w_cnt) < remaining)) begin
                grant[i] = 1'b1;
                w_cnt    = w_cnt + KW'(1);
            end
        end
        k = w_cnt;
    end

endmodule

// File: rtl/rom_dispatch_ctrl.sv
// rom_dispatch_ctrl
// Burst sequencer for custom_rom. Accepts (base_addr, length), then issues one
// multi-word ROM read per cycle sized to the ready downstream ports, and
// produces a per-port valid aligned with the ROM's registered data_out.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : command strobe (ignored while busy)
//   base_addr       : first ROM word of the burst
//   length          : words to dispatch, 0..2**LOG_ROM_SIZE
//   abort           : synchronous burst cancel, no done pulse
//   port_ready      : per-port downstream ready
//   busy            : RUN or DRAIN
//   done            : one-cycle completion pulse
//   rom_read        : ROM read enable
//   rom_addr        : address of the first word of this beat
//   rom_stall_word  : 1 = port not served this beat
//   rom_n_v_out     : words requested this beat
//   port_valid      : ports carrying ROM data this cycle (read delayed 1 cycle)
module rom_dispatch_ctrl
    import rom_dispatch_pkg::*;
#(
    parameter int LOG_ROM_SIZE  = DEF_LOG_ROM_SIZE,
    parameter int LOG_OUT_PORTS = DEF_LOG_OUT_PORTS,
    localparam int NPORTS = nports_f(LOG_OUT_PORTS),
    localparam int KW     = grant_cnt_w_f(LOG_OUT_PORTS),
    localparam int RW     = rem_w_f(LOG_ROM_SIZE)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LOG_ROM_SIZE-1:0] base_addr,
    input  logic [RW-1:0]           length,
    input  logic                    abort,
    input  logic [NPORTS-1:0]       port_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    rom_read,
    output logic [LOG_ROM_SIZE-1:0] rom_addr,
    output logic [NPORTS-1:0]       rom_stall_word,
    output logic [KW-1:0]           rom_n_v_out,
    output logic [NPORTS-1:0]       port_valid
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LOG_ROM_SIZE-1:0] r_addr;
    logic [RW-1:0]           r_remaining;
    logic [NPORTS-1:0]       r_port_valid;
    logic                    r_zero_done;

    logic [NPORTS-1:0]       w_grant;
    logic [KW-1:0]           w_k;
    logic                    w_run;
    logic                    w_read;
    logic                    w_accept;
    logic                    w_last_beat;

    dispatch_grant_sel #(
        .LOG_ROM_SIZE  (LOG_ROM_SIZE),
        .LOG_OUT_PORTS (LOG_OUT_PORTS)
    ) u_grant_sel (
        .port_ready (port_ready),
        .remaining  (r_remaining),
        .grant      (w_grant),
        .k          (w_k)
    );

    assign w_run       = (r_state == RUN);
    assign w_read      = w_run && (w_k != '0);
    // abort beats start when both arrive together in IDLE
    assign w_accept    = (r_state == IDLE) && start && !abort;
    assign w_last_beat = w_read && (r_remaining == RW'(w_k));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && (length != '0)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_last_beat) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_port_valid <= '0;
            r_zero_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            // a read in the abort cycle still delivers its data
            r_port_valid <= w_read ? w_grant : '0;
            r_zero_done  <= w_accept && (length == '0);
            if (w_accept && (length != '0)) begin
                r_addr      <= base_addr;
                r_remaining <= length;
            end else if (w_run && abort) begin
                r_remaining <= '0;
            end else if (w_read) begin
                r_addr      <= r_addr + LOG_ROM_SIZE'(w_k);
                r_remaining <= r_remaining - RW'(w_k);
            end
        end
    end

    // DRAIN is the cycle of the last port_valid; a zero-length command pulses
    // done from its own flag while busy stays low.
    assign done           = ((r_state == DRAIN) && !abort) || r_zero_done;
    assign busy           = w_run || (r_state == DRAIN);
    assign rom_read       = w_read;
    assign rom_addr       = w_run ? r_addr : '0;
    assign rom_stall_word = w_run ? ~w_grant : '1;
    assign rom_n_v_out    = w_run ? w_k : '0;
    assign port_valid     = r_port_valid;

endmodule

// File: tb/tb_rom_dispatch_ctrl.sv
module tb_rom_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       abort;
    logic [3:0] port_ready;
    logic       busy;
    logic       done;
    logic       rom_read;
    logic [7:0] rom_addr;
    logic [3:0] rom_stall_word;
    logic [2:0] rom_n_v_out;
    logic [3:0] port_valid;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] stall;
        logic [2:0] n;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] pv_next = '0;

    rom_dispatch_ctrl #(
        .LOG_ROM_SIZE  (8),
        .LOG_OUT_PORTS (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .abort          (abort),
        .port_ready     (port_ready),
        .busy           (busy),
        .done           (done),
        .rom_read       (rom_read),
        .rom_addr       (rom_addr),
        .rom_stall_word (rom_stall_word),
        .rom_n_v_out    (rom_n_v_out),
        .port_valid     (port_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [7:0] a, input logic [3:0] s, input logic [2:0] n);
        beat_t b;
        b.addr  = a;
        b.stall = s;
        b.n     = n;
        exp_q.push_back(b);
    endtask

    task automatic cmd(input logic [7:0] b, input logic [8:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [3:0] exp_pv);
        bit got = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                chk({tag, "_last_pv"}, {28'd0, port_valid}, {28'd0, exp_pv});
                chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
                break;
            end
        end
        if (!got) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
        chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
    endtask

    // Scoreboard monitor: every read must match the next expected beat, and
    // the following cycle must show exactly the served ports as valid.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv_next = '0;
            end else begin
                chk("port_valid", {28'd0, port_valid}, {28'd0, pv_next});
                pv_next = '0;
                if (done) done_cnt++;
                if (rom_read) begin
                    if (exp_q.size() == 0) begin
                        chk("rd_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rom_addr", {24'd0, rom_addr}, {24'd0, e.addr});
                        chk("rom_stall", {28'd0, rom_stall_word}, {28'd0, e.stall});
                        chk("rom_n", {29'd0, rom_n_v_out}, {29'd0, e.n});
                        $display("beat addr=%02h stall=%01h n=%0d", rom_addr, rom_stall_word, rom_n_v_out);
                        pv_next = ~e.stall;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        abort      = 1'b0;
        port_ready = 4'hF;
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_read", {31'd0, rom_read}, 32'd0);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_stall", {28'd0, rom_stall_word}, 32'hF);
        chk("rst_n", {29'd0, rom_n_v_out}, 32'd0);
        chk("rst_pv", {28'd0, port_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        tick();

        // base 0x10, length 8, all ready
        push_beat(8'h10, 4'h0, 3'd4);
        push_beat(8'h14, 4'h0, 3'd4);
        cmd(8'h10, 9'd8);
        wait_done("t1", 4'hF);

        // base 0x28, length 6: trimmed final beat
        push_beat(8'h28, 4'h0, 3'd4);
        push_beat(8'h2C, 4'hC, 3'd2);
        cmd(8'h28, 9'd6);
        wait_done("t2", 4'h3);

        // base 0x3B, length 4, partial ready then full ready
        port_ready = 4'hD;
        push_beat(8'h3B, 4'h2, 3'd3);
        push_beat(8'h3E, 4'hE, 3'd1);
        cmd(8'h3B, 9'd4);
        tick();
        port_ready = 4'hF;
        wait_done("t3", 4'h1);

        // ready drops to zero for 3 cycles mid-burst
        push_beat(8'h40, 4'h0, 3'd4);
        push_beat(8'h44, 4'h0, 3'd4);
        push_beat(8'h48, 4'h0, 3'd4);
        cmd(8'h40, 9'd12);
        tick();
        port_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_read", {31'd0, rom_read}, 32'd0);
            chk("stall_busy", {31'd0, busy}, 32'd1);
            chk("stall_sw", {28'd0, rom_stall_word}, 32'hF);
            chk("stall_n", {29'd0, rom_n_v_out}, 32'd0);
            tick();
        end
        port_ready = 4'hF;
        wait_done("t4", 4'hF);

        // address wrap, and a start while busy is ignored
        push_beat(8'hFE, 4'h0, 3'd4);
        push_beat(8'h02, 4'hC, 3'd2);
        cmd(8'hFE, 9'd6);
        start     = 1'b1;
        base_addr = 8'h80;
        length    = 9'd3;
        tick();
        start     = 1'b0;
        wait_done("t5", 4'h3);

        // zero length: done pulse, no read, not busy
        d0 = done_cnt;
        cmd(8'h50, 9'd0);
        @(negedge clk);
        chk("len0_done", {31'd0, done}, 32'd1);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_read", {31'd0, rom_read}, 32'd0);
        tick();
        @(negedge clk);
        chk("len0_done_fall", {31'd0, done}, 32'd0);
        chk("len0_done_cnt", done_cnt - d0, 32'd1);

        // full-size burst: 256 words in 64 beats
        for (int i = 0; i < 64; i++) push_beat(8'(i * 4), 4'h0, 3'd4);
        cmd(8'h00, 9'h100);
        wait_done("t6", 4'hF);

        // abort one cycle after start: the single read still yields valid
        d0 = done_cnt;
        push_beat(8'h60, 4'h0, 3'd4);
        cmd(8'h60, 9'd8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_done", {31'd0, done}, 32'd0);
            tick();
        end
        chk("abort_done_cnt", done_cnt - d0, 32'd0);
        chk("abort_q_empty", exp_q.size(), 32'd0);

        // abort and start together in IDLE: start dropped
        d0 = done_cnt;
        start     = 1'b1;
        abort     = 1'b1;
        base_addr = 8'h20;
        length    = 9'd5;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abst_busy", {31'd0, busy}, 32'd0);
            tick();
        end
        chk("abst_done_cnt", done_cnt - d0, 32'd0);

        // reset mid-RUN: outputs return to reset values without a clock edge
        push_beat(8'h70, 4'h0, 3'd4);
        cmd(8'h70, 9'd16);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_read", {31'd0, rom_read}, 32'd0);
        chk("mid_rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("mid_rst_stall", {28'd0, rom_stall_word}, 32'hF);
        chk("mid_rst_n", {29'd0, rom_n_v_out}, 32'd0);
        chk("mid_rst_pv", {28'd0, port_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
